// File: rtl/pipearch_common.sv
// Shared definitions for the region read path: select codes, reader FSM states
// and a saturating counter helper.
package pipearch_common;

  localparam logic [1:0] REGION_SEL_NONE = 2'b00;
  localparam logic [1:0] REGION_SEL_BRAM = 2'b01;
  localparam logic [1:0] REGION_SEL_FIFO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } region_reader_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small circular buffer with a registered head word and an occupancy count;
// used as the credit-protected output buffer of the region reader.
module stream_skid_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s;
  logic             push_ok_s;

  assign pop_s     = (count_r != {CNT_W{1'b0}}) && out_ready;
  assign push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_s);

  // pointer and occupancy update; occupancy moves by the net change
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array, data only
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/region_stream_reader.sv
// Read engine for one region read channel: issues re pulses under a credit
// rule and streams returned words out. Optional stall counters: REGION_READER_STATS_EN.
module region_stream_reader
  import pipearch_common::*;
#(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 9,
  parameter int OUT_DEPTH  = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_fifo,
  input  logic [LOG2_DEPTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  region_re,
  output logic [1:0]            region_rfifobram,
  output logic [LOG2_DEPTH-1:0] region_raddr,
  input  logic                  region_rvalid,
  input  logic [WIDTH-1:0]      region_rdata,
  input  logic                  region_empty,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  done
`ifdef REGION_READER_STATS_EN
  ,
  output logic [31:0]           stat_stall_credit,
  output logic [31:0]           stat_stall_empty
`endif
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  region_reader_state_t  state_r;
  region_reader_state_t  state_s;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [LOG2_DEPTH-1:0] addr_r;
  logic [1:0]            sel_r;
  logic                  fifo_mode_r;
  logic                  inflight_r;
  logic                  cmd_ready_r;
  logic                  done_r;
  logic                  done_s;
  logic [CNT_W-1:0]      occ_s;
  logic                  credit_ok_s;
  logic                  src_ok_s;
  logic                  issue_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  drain_ok_s;
  logic                  buf_valid_s;

  // credit uses registered occupancy only, so out_ready never reaches region_re
  assign credit_ok_s = (occ_s + CNT_W'(inflight_r)) < CNT_W'(OUT_DEPTH);
  assign src_ok_s    = !fifo_mode_r || !region_empty;
  assign issue_s     = !reset && (state_r == ST_RUN) && (remaining_r != {LEN_WIDTH{1'b0}})
                       && credit_ok_s && src_ok_s;
  assign accept_s    = cmd_valid && cmd_ready_r;
  assign push_s      = region_rvalid && inflight_r;
  assign drain_ok_s  = !inflight_r && ((occ_s == {CNT_W{1'b0}}) ||
                       ((occ_s == CNT_W'(1)) && out_ready));

  // next-state and completion decode
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = (cmd_len == {LEN_WIDTH{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((remaining_r == {LEN_WIDTH{1'b0}}) ||
            (issue_s && (remaining_r == LEN_WIDTH'(1)))) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_ok_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // command context, issue tracking and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      done_r      <= 1'b0;
      inflight_r  <= 1'b0;
      remaining_r <= {LEN_WIDTH{1'b0}};
      addr_r      <= {LOG2_DEPTH{1'b0}};
      sel_r       <= REGION_SEL_NONE;
      fifo_mode_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      done_r      <= done_s;
      if (issue_s) begin
        inflight_r <= 1'b1;
      end else if (region_rvalid) begin
        inflight_r <= 1'b0;
      end
      if (accept_s) begin
        remaining_r <= cmd_len;
        addr_r      <= cmd_fifo ? {LOG2_DEPTH{1'b0}} : cmd_addr;
        sel_r       <= cmd_fifo ? REGION_SEL_FIFO : REGION_SEL_BRAM;
        fifo_mode_r <= cmd_fifo;
      end else if (issue_s) begin
        remaining_r <= remaining_r - LEN_WIDTH'(1);
        if (!fifo_mode_r) begin
          addr_r <= addr_r + LOG2_DEPTH'(1);
        end
      end else if (done_s) begin
        sel_r <= REGION_SEL_NONE;
      end
    end
  end

  stream_skid_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (region_rdata),
    .out_valid (buf_valid_s),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (occ_s)
  );

  assign out_valid        = buf_valid_s;
  assign cmd_ready        = cmd_ready_r;
  assign done             = done_r;
  assign region_re        = issue_s;
  assign region_rfifobram = sel_r;
  assign region_raddr     = addr_r;

`ifdef REGION_READER_STATS_EN
  logic [31:0] stall_credit_r;
  logic [31:0] stall_empty_r;

  // saturating stall counters, restarted by each accepted command
  always_ff @(posedge clk) begin
    if (reset || accept_s) begin
      stall_credit_r <= 32'd0;
      stall_empty_r  <= 32'd0;
    end else begin
      if ((state_r == ST_RUN) && (remaining_r != {LEN_WIDTH{1'b0}}) && !credit_ok_s) begin
        stall_credit_r <= sat_inc32(stall_credit_r);
      end
      if ((state_r == ST_RUN) && (remaining_r != {LEN_WIDTH{1'b0}}) && fifo_mode_r && region_empty) begin
        stall_empty_r <= sat_inc32(stall_empty_r);
      end
    end
  end

  assign stat_stall_credit = stall_credit_r;
  assign stat_stall_empty  = stall_empty_r;
`else
`endif

endmodule

// File: tb/tb_region_stream_reader.sv
// Directed self-checking bench for region_stream_reader with a one-cycle-latency
// region model (BRAM words = A000_0000|addr, FIFO words = F000_0000+n).
module tb_region_stream_reader;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int OD = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_fifo = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          region_re;
  logic [1:0]    region_rfifobram;
  logic [AW-1:0] region_raddr;
  logic          region_rvalid = 1'b0;
  logic [W-1:0]  region_rdata = '0;
  logic          region_empty = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b1;
  logic          done;
`ifdef REGION_READER_STATS_EN
  logic [31:0]   stat_stall_credit;
  logic [31:0]   stat_stall_empty;
`endif

  always #5 clk = ~clk;

  region_stream_reader #(.WIDTH(W), .LOG2_DEPTH(AW), .OUT_DEPTH(OD), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_fifo         (cmd_fifo),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .region_re        (region_re),
    .region_rfifobram (region_rfifobram),
    .region_raddr     (region_raddr),
    .region_rvalid    (region_rvalid),
    .region_rdata     (region_rdata),
    .region_empty     (region_empty),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .done             (done)
`ifdef REGION_READER_STATS_EN
    ,
    .stat_stall_credit (stat_stall_credit),
    .stat_stall_empty  (stat_stall_empty)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // region model: one-cycle read latency
  logic [31:0] fcnt = 32'd0;
  always @(posedge clk) begin
    region_rvalid <= region_re;
    if (region_re) begin
      if (region_rfifobram == 2'b10) begin
        region_rdata <= 32'hF000_0000 + fcnt;
        fcnt         <= fcnt + 32'd1;
      end else begin
        region_rdata <= 32'hA000_0000 | {28'd0, region_raddr};
      end
    end
  end

  logic toggle_en = 1'b0;
  always @(posedge clk) begin
    #1;
    region_empty = toggle_en ? (((cyc / 3) % 2) == 1) : 1'b0;
  end

  int tests_run = 0;
  int tests_failed = 0;
  int re_cnt, re_empty_viol, sel_err, stable_err, done_cnt, ov_cnt;
  int first_ov_cyc, done_cyc, re_cyc_first, re_cyc_last;
  logic          sel_chk_en = 1'b0;
  logic [1:0]    exp_sel = 2'b00;
  logic          prev_hold = 1'b0;
  logic [W-1:0]  prev_data = '0;
  logic [AW-1:0] addr_q[$];
  logic [W-1:0]  out_q[$];

  // bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (region_re) begin
      re_cnt++;
      addr_q.push_back(region_raddr);
      if (re_cnt == 1) re_cyc_first = cyc;
      re_cyc_last = cyc;
      if (region_empty && (region_rfifobram == 2'b10)) re_empty_viol++;
    end
    if (sel_chk_en && !cmd_ready && (region_rfifobram != exp_sel)) sel_err++;
    if (out_valid) begin
      ov_cnt++;
      if (ov_cnt == 1) first_ov_cyc = cyc;
      if (prev_hold && (out_data != prev_data)) stable_err++;
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    re_cnt = 0; re_empty_viol = 0; sel_err = 0; stable_err = 0;
    done_cnt = 0; ov_cnt = 0;
    first_ov_cyc = -1; done_cyc = -1; re_cyc_first = -1; re_cyc_last = -1;
    addr_q.delete();
    out_q.delete();
  endtask

  task automatic send_cmd(input logic fifo, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, output int hs);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_fifo  = fifo;
    cmd_addr  = addr;
    cmd_len   = len;
    hs        = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    step();
    step();
  endtask

  task automatic check_words(input string tag, input int n, input logic [W-1:0] base,
                             input logic fifo_words);
    logic [W-1:0] exp;
    check_eq({tag, "_word_count"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      if (fifo_words) exp = base + W'(i);
      else            exp = 32'hA000_0000 | {28'd0, AW'(base + W'(i))};
      check_eq($sformatf("%s_word%0d", tag, i), 64'(out_q[i]), 64'(exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int fbase;
    clear_mon();
    // reset state
    step(); step(); step();
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_region_re", 64'(region_re), 64'd0);
    check_eq("rst_rfifobram", 64'(region_rfifobram), 64'd0);
    check_eq("rst_raddr", 64'(region_raddr), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    step(); step();
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // BRAM read, addr 5, len 8
    clear_mon();
    send_cmd(1'b0, 4'd5, 16'd8, hs);
    wait_done(40, "bram");
    check_eq("bram_re_count", 64'(re_cnt), 64'd8);
    check_eq("bram_first_re_cyc", 64'(re_cyc_first), 64'(hs + 1));
    check_eq("bram_last_re_cyc", 64'(re_cyc_last), 64'(hs + 8));
    for (int i = 0; i < 8 && i < addr_q.size(); i++)
      check_eq($sformatf("bram_addr%0d", i), 64'(addr_q[i]), 64'(5 + i));
    check_eq("bram_first_out_cyc", 64'(first_ov_cyc), 64'(hs + 3));
    check_eq("bram_done_cyc", 64'(done_cyc), 64'(hs + 11));
    check_eq("bram_done_pulses", 64'(done_cnt), 64'd1);
    check_words("bram", 8, 32'd5, 1'b0);
    check_eq("bram_idle_sel", 64'(region_rfifobram), 64'd0);

    // address wrap 14, 15, 0, 1
    clear_mon();
    send_cmd(1'b0, 4'd14, 16'd4, hs);
    wait_done(40, "wrap");
    check_eq("wrap_addr0", 64'(addr_q[0]), 64'd14);
    check_eq("wrap_addr1", 64'(addr_q[1]), 64'd15);
    check_eq("wrap_addr2", 64'(addr_q[2]), 64'd0);
    check_eq("wrap_addr3", 64'(addr_q[3]), 64'd1);
    check_words("wrap", 4, 32'd14, 1'b0);

    // backpressure: out_ready low for 20 cycles
    clear_mon();
    out_ready = 1'b0;
    send_cmd(1'b0, 4'd0, 16'd10, hs);
    repeat (20) step();
    check_eq("bp_re_while_blocked", 64'(re_cnt), 64'(OD));
    check_eq("bp_out_valid_held", 64'(out_valid), 64'd1);
    check_eq("bp_no_pops", 64'(out_q.size()), 64'd0);
    out_ready = 1'b1;
    wait_done(60, "bp");
    check_eq("bp_re_total", 64'(re_cnt), 64'd10);
    check_eq("bp_data_stable", 64'(stable_err), 64'd0);
    check_words("bp", 10, 32'd0, 1'b0);

    // FIFO mode with region_empty toggling every 3 cycles
    clear_mon();
    fbase = int'(fcnt);
    toggle_en = 1'b1;
    exp_sel = 2'b10;
    sel_chk_en = 1'b1;
    send_cmd(1'b1, 4'd3, 16'd6, hs);
    wait_done(80, "fifo");
    sel_chk_en = 1'b0;
    toggle_en = 1'b0;
    check_eq("fifo_re_while_empty", 64'(re_empty_viol), 64'd0);
    check_eq("fifo_re_count", 64'(re_cnt), 64'd6);
    check_eq("fifo_sel_held", 64'(sel_err), 64'd0);
    check_words("fifo", 6, 32'hF000_0000 + W'(fbase), 1'b1);
    check_eq("fifo_idle_sel", 64'(region_rfifobram), 64'd0);

    // zero-length command
    clear_mon();
    send_cmd(1'b0, 4'd2, 16'd0, hs);
    wait_done(10, "len0");
    check_eq("len0_re_count", 64'(re_cnt), 64'd0);
    check_eq("len0_done_cyc", 64'(done_cyc), 64'(hs + 2));
    check_eq("len0_no_words", 64'(out_q.size()), 64'd0);

    // reset one cycle after the first region_re
    clear_mon();
    send_cmd(1'b0, 4'd0, 16'd4, hs);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    clear_mon();
    repeat (8) step();
    check_eq("midrst_no_out_valid", 64'(ov_cnt), 64'd0);
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);
    check_eq("midrst_no_re", 64'(re_cnt), 64'd0);
    send_cmd(1'b0, 4'd7, 16'd3, hs);
    wait_done(40, "after_rst");
    check_eq("after_rst_done_pulses", 64'(done_cnt), 64'd1);
    check_words("after_rst", 3, 32'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
